// File: rtl/d_write_buffer.sv
// Posted-write queue between the D-cache and the AXI write channels: buffers line
// evictions and uncached single-word stores, drains them in order as AXI bursts.
module d_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic                    wb_single,
    input  logic [31:0]             wb_addr,
    input  logic [32*LINE_WORDS-1:0] wb_data,
    input  logic [3:0]              wb_strb,
    input  logic [31:0]             rd_addr,
    output logic                    rd_hit,
    output logic                    drained,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a >> OFF_W;
    endfunction

    function automatic logic [31:0] issue_addr(input logic [31:0] a, input logic single);
        return single ? a : {a[31:OFF_W], {OFF_W{1'b0}}};
    endfunction

    function automatic logic [7:0] issue_len(input logic single);
        return single ? 8'd0 : LINE_LEN;
    endfunction

    logic [31:0]             addr_mem [DEPTH];
    logic [32*LINE_WORDS-1:0] data_mem [DEPTH];
    logic [3:0]              strb_mem [DEPTH];
    logic [DEPTH-1:0]        single_mem;

    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    state_t            state_r;
    logic [BEAT_W-1:0] beat_r;

    logic              push_s, pop_s, more_s, hit_s;
    logic [PTR_W-1:0]  nxt_idx_s, rel_s;
    logic [31:0]       nxt_addr_s;
    logic              nxt_single_s;
    logic [BEAT_W-1:0] next_beat_s;
    logic [31:0]       next_word_s;

    assign wb_ready = (count_r != CNT_W'(DEPTH));
    assign push_s   = wb_valid & wb_ready;
    assign pop_s    = bready & bvalid;
    assign more_s   = (count_r > CNT_W'(1)) | push_s;
    assign drained  = (count_r == {CNT_W{1'b0}}) & (state_r == ST_IDLE);
    assign awsize   = 3'd2;
    assign rd_hit   = hit_s;

    // Entry storage; written only on an accepted push, so it needs no reset.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            addr_mem[wr_ptr_r]   <= wb_addr;
            data_mem[wr_ptr_r]   <= wb_data;
            strb_mem[wr_ptr_r]   <= wb_single ? wb_strb : 4'hf;
            single_mem[wr_ptr_r] <= wb_single;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next head after a pop; when only the incoming push remains it is bypassed from the port.
    always_comb begin
        nxt_idx_s = rd_ptr_r + PTR_W'(1);
        if (count_r == CNT_W'(1)) begin
            nxt_addr_s   = wb_addr;
            nxt_single_s = wb_single;
        end else begin
            nxt_addr_s   = addr_mem[nxt_idx_s];
            nxt_single_s = single_mem[nxt_idx_s];
        end
        next_beat_s = beat_r + BEAT_W'(1);
        next_word_s = data_mem[rd_ptr_r][{next_beat_s, 5'b00000} +: 32];
    end

    // Line hazard against every live entry plus the push being accepted this cycle.
    always_comb begin
        rel_s = {PTR_W{1'b0}};
        hit_s = push_s & (line_of(wb_addr) == line_of(rd_addr));
        for (int i = 0; i < DEPTH; i++) begin
            rel_s = PTR_W'(i) - rd_ptr_r;
            hit_s = hit_s | ((CNT_W'(rel_s) < count_r) &
                             (line_of(addr_mem[i]) == line_of(rd_addr)));
        end
    end

    // Burst sequencer for the head entry with registered AXI outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
            beat_r  <= {BEAT_W{1'b0}};
            awvalid <= 1'b0;
            awaddr  <= 32'd0;
            awlen   <= 8'd0;
            wvalid  <= 1'b0;
            wdata   <= 32'd0;
            wstrb   <= 4'd0;
            wlast   <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (count_r != {CNT_W{1'b0}}) begin
                        state_r <= ST_AW;
                        awvalid <= 1'b1;
                        awaddr  <= issue_addr(addr_mem[rd_ptr_r], single_mem[rd_ptr_r]);
                        awlen   <= issue_len(single_mem[rd_ptr_r]);
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        state_r <= ST_W;
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        beat_r  <= {BEAT_W{1'b0}};
                        wdata   <= data_mem[rd_ptr_r][31:0];
                        wstrb   <= strb_mem[rd_ptr_r];
                        wlast   <= (awlen == 8'd0);
                    end
                end
                ST_W: begin
                    if (wready) begin
                        if (wlast) begin
                            state_r <= ST_B;
                            wvalid  <= 1'b0;
                            wlast   <= 1'b0;
                            bready  <= 1'b1;
                        end else begin
                            beat_r <= next_beat_s;
                            wdata  <= next_word_s;
                            wlast  <= (8'(next_beat_s) == awlen);
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (more_s) begin
                            state_r <= ST_AW;
                            awvalid <= 1'b1;
                            awaddr  <= issue_addr(nxt_addr_s, nxt_single_s);
                            awlen   <= issue_len(nxt_single_s);
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_d_write_buffer.sv
// Scoreboard bench for d_write_buffer: expected AW/W beats are queued at push time
// and compared as the DUT presents them; an AXI slave model applies stalls.
module tb_d_write_buffer;
    logic         clk = 1'b0;
    logic         aresetn;
    logic         wb_valid, wb_ready, wb_single;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic [3:0]   wb_strb;
    logic [31:0]  rd_addr;
    logic         rd_hit, drained;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic         bvalid, bready;

    d_write_buffer #(.DEPTH(4), .LINE_WORDS(8)) dut (
        .aclk(clk), .aresetn(aresetn),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_single(wb_single),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_strb(wb_strb),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .drained(drained),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_exp_t;

    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];

    int vectors = 0;
    int miscompares = 0;
    int aw_mode = 0, w_mode = 0, b_mode = 0;
    int pending_b = 0, b_done = 0, w_hs = 0, pushed = 0, snap_b = 0;
    logic in_burst = 1'b0, b_hs_last = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ready_of(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // AXI slave model: choose ready/valid first, then score the handshakes they imply.
    task automatic axi_responder();
        aw_exp_t ea;
        w_exp_t  ew;
        logic    new_b;
        forever begin
            @(negedge clk);
            new_b   = 1'b0;
            awready = ready_of(aw_mode);
            wready  = ready_of(w_mode);
            if (bvalid && !b_hs_last) bvalid = 1'b1;
            else bvalid = (pending_b > 0) && ((b_mode == 0) || ($urandom_range(0, 1) == 1));
            if (aresetn) begin
                if (awvalid) begin
                    if (exp_aw.size() == 0) check_eq("aw_unexpected", 32'(awvalid), 32'd0);
                    else begin
                        ea = exp_aw[0];
                        check_eq("awaddr", awaddr, ea.addr);
                        check_eq("awlen", 32'(awlen), 32'(ea.len));
                        check_eq("awsize", 32'(awsize), 32'd2);
                        check_eq("aw_w_overlap", 32'(wvalid), 32'd0);
                        if (awready) void'(exp_aw.pop_front());
                    end
                end
                if (in_burst) check_eq("wvalid_hold", 32'(wvalid), 32'd1);
                if (wvalid) begin
                    if (exp_w.size() == 0) check_eq("w_unexpected", 32'(wvalid), 32'd0);
                    else begin
                        ew = exp_w[0];
                        check_eq("wdata", wdata, ew.data);
                        check_eq("wstrb", 32'(wstrb), 32'(ew.strb));
                        check_eq("wlast", 32'(wlast), 32'(ew.last));
                        if (wready) begin
                            void'(exp_w.pop_front());
                            w_hs++;
                            in_burst = !ew.last;
                            new_b = ew.last;
                        end
                    end
                end
                b_hs_last = bvalid && bready;
                if (b_hs_last) begin
                    pending_b--;
                    b_done++;
                end
                if (new_b) pending_b++;
            end else begin
                b_hs_last = 1'b0;
            end
        end
    endtask

    task automatic push_entry(input logic single, input logic [31:0] addr,
                              input logic [255:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        wb_valid = 1'b1; wb_single = single; wb_addr = addr; wb_data = data; wb_strb = strb;
        n = 0;
        while (!wb_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!wb_ready) begin
            check_eq("push_timeout", 32'(wb_ready), 32'd1);
            wb_valid = 1'b0;
        end else begin
            snap_b = b_done;
            pushed++;
            if (single) begin
                exp_aw.push_back('{addr: addr, len: 8'd0});
                exp_w.push_back('{data: data[31:0], strb: strb, last: 1'b1});
            end else begin
                exp_aw.push_back('{addr: addr & 32'hFFFF_FFE0, len: 8'd7});
                for (int i = 0; i < 8; i++)
                    exp_w.push_back('{data: data[32*i +: 32], strb: 4'hf, last: (i == 7)});
            end
            @(posedge clk);
            #1 wb_valid = 1'b0;
        end
    endtask

    task automatic wait_drained(input int bound);
        int n = 0;
        while (!drained && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_eq("drained", 32'(drained), 32'd1);
    endtask

    function automatic logic [255:0] line_data(input logic [31:0] base);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = base + 32'(i);
        return d;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        aresetn = 1'b0; wb_valid = 1'b0; wb_single = 1'b0; wb_addr = 32'd0;
        wb_data = 256'd0; wb_strb = 4'd0; rd_addr = 32'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        fork axi_responder(); join_none
        repeat (3) @(negedge clk);
        check_eq("rst_awvalid", 32'(awvalid), 32'd0);
        check_eq("rst_wvalid", 32'(wvalid), 32'd0);
        check_eq("rst_bready", 32'(bready), 32'd0);
        check_eq("rst_wlast", 32'(wlast), 32'd0);
        check_eq("rst_wb_ready", 32'(wb_ready), 32'd1);
        check_eq("rst_drained", 32'(drained), 32'd1);
        check_eq("rst_rd_hit", 32'(rd_hit), 32'd0);
        aresetn = 1'b1;

        // Line then single store, all channels always ready.
        push_entry(1'b0, 32'h1000_0040, line_data(32'hA0), 4'hf);
        check_eq("busy_after_push", 32'(drained), 32'd0);
        wait_drained(100);
        push_entry(1'b1, 32'h1FAF_F004, {224'd0, 32'h1234_5678}, 4'b0011);
        wait_drained(100);

        // Fill with AW blocked; fifth push waits for the first B.
        aw_mode = 2;
        for (int k = 0; k < 4; k++) push_entry(1'b0, 32'h4000_0000 + 32'(k * 32), line_data(32'(k) << 8), 4'hf);
        check_eq("full_ready", 32'(wb_ready), 32'd0);
        fork
            push_entry(1'b1, 32'h4000_1000, {224'd0, 32'hCAFE_0005}, 4'hc);
            begin repeat (5) @(negedge clk); aw_mode = 0; end
        join
        check_eq("fifth_after_b", 32'(snap_b != 0), 32'd1);
        wait_drained(300);

        // Hazard detection.
        aw_mode = 2;
        push_entry(1'b0, 32'h0000_2000, line_data(32'h2000), 4'hf);
        @(negedge clk);
        rd_addr = 32'h0000_2014; #1 check_eq("hit_same_line", 32'(rd_hit), 32'd1);
        rd_addr = 32'h0000_2020; #1 check_eq("hit_next_line", 32'(rd_hit), 32'd0);
        @(negedge clk);
        wb_valid = 1'b1; wb_single = 1'b1; wb_addr = 32'h0000_3000; rd_addr = 32'h0000_3008;
        #1 check_eq("hit_incoming", 32'(rd_hit), 32'd1);
        wb_valid = 1'b0;
        #1 check_eq("hit_no_push", 32'(rd_hit), 32'd0);
        rd_addr = 32'h0000_2014;
        aw_mode = 0;
        wait_drained(100);
        check_eq("hit_after_pop", 32'(rd_hit), 32'd0);

        // Random traffic with stalls on every channel.
        aw_mode = 1; w_mode = 1; b_mode = 1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 2) == 0)
                push_entry(1'b1, $urandom & 32'hFFFF_FFFC, {224'd0, 32'($urandom)}, 4'($urandom_range(1, 15)));
            else
                push_entry(1'b0, $urandom, rand_line(), 4'hf);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drained(8000);
        check_eq("aw_queue_empty", 32'(exp_aw.size()), 32'd0);
        check_eq("w_queue_empty", 32'(exp_w.size()), 32'd0);
        check_eq("b_count", 32'(b_done), 32'(pushed));

        // Reset in the middle of a burst.
        aw_mode = 0; w_mode = 0; b_mode = 0;
        n = w_hs;
        push_entry(1'b0, 32'h5000_0000, line_data(32'h50), 4'hf);
        while (w_hs < n + 4 && w_hs < n + 400) begin
            @(negedge clk); #1;
        end
        check_eq("mid_burst", 32'(wvalid), 32'd1);
        aresetn = 1'b0;
        exp_aw.delete(); exp_w.delete();
        pending_b = 0; in_burst = 1'b0; b_done = 0; pushed = 0;
        #1 check_eq("rst_mid_wvalid", 32'(wvalid), 32'd0);
        check_eq("rst_mid_wb_ready", 32'(wb_ready), 32'd1);
        check_eq("rst_mid_drained", 32'(drained), 32'd1);
        repeat (2) @(negedge clk);
        #1 aresetn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("post_rst_awvalid", 32'(awvalid), 32'd0);
            check_eq("post_rst_drained", 32'(drained), 32'd1);
        end
        push_entry(1'b1, 32'h6000_0008, {224'd0, 32'h0BAD_F00D}, 4'hf);
        wait_drained(100);
        check_eq("post_rst_b_count", 32'(b_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
